// File: rtl/signal_debouncer_pkg.sv
// Shared helpers for the input-conditioning blocks.
package signal_debouncer_pkg;

  // Width of a counter that must hold every value 0..max_count without wrapping.
  function automatic int unsigned cnt_width(input int unsigned max_count);
    return (max_count < 1) ? 1 : $clog2(max_count + 1);
  endfunction

endpackage : signal_debouncer_pkg

// File: rtl/signal_sync.sv
// Multi-flop synchroniser for a single asynchronous level.
// Plain shift chain, no logic between stages, so it can be reused by any input stage.
module signal_sync #(
  parameter int unsigned Stages     = 2,
  parameter bit          ResetValue = 1'b0
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  if (Stages < 2) begin : g_bad_stages
    $error("signal_sync: Stages must be at least 2");
  end

  logic [Stages-1:0] r_chain;

  // Shift the raw level through the chain; bit 0 is the metastability-exposed flop.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_chain <= {Stages{ResetValue}};
    end else begin
      r_chain <= {r_chain[Stages-2:0], d_i};
    end
  end

  assign q_o = r_chain[Stages-1];

endmodule : signal_sync

// File: rtl/signal_debouncer.sv
// Synchronise, debounce and edge-detect a raw asynchronous level.
// A change on the synchronised input must persist for DebounceCycles consecutive
// samples before it is committed to signal_o; rise_o/fall_o flag the first cycle
// of each committed change and busy_o shows that a candidate is being counted.
module signal_debouncer
  import signal_debouncer_pkg::*;
#(
  parameter int unsigned SyncStages     = 2,
  parameter int unsigned DebounceCycles = 4,
  parameter bit          ResetValue     = 1'b0
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic signal_i,
  output logic signal_o,
  output logic rise_o,
  output logic fall_o,
  output logic busy_o
);

  if (SyncStages < 2) begin : g_bad_sync
    $error("signal_debouncer: SyncStages must be at least 2");
  end
  if (DebounceCycles < 1) begin : g_bad_debounce
    $error("signal_debouncer: DebounceCycles must be at least 1");
  end

  localparam int unsigned     CntW    = cnt_width(DebounceCycles);
  localparam logic [CntW-1:0] LastCnt = CntW'(DebounceCycles - 1);

  typedef enum logic {
    ST_STABLE = 1'b0,
    ST_CHECK  = 1'b1
  } state_e;

  state_e          r_state;
  state_e          w_state_nxt;
  logic [CntW-1:0] r_cnt;
  logic [CntW-1:0] w_cnt_nxt;
  logic            r_level;
  logic            r_rise;
  logic            r_fall;
  logic            w_sync_s;
  logic            w_diff;
  logic            w_commit;

  signal_sync #(
    .Stages     (SyncStages),
    .ResetValue (ResetValue)
  ) u_sync (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .d_i    (signal_i),
    .q_o    (w_sync_s)
  );

  assign w_diff = (w_sync_s != r_level);

  // Next state: count agreeing samples of a candidate change, drop it on any glitch.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_commit    = 1'b0;
    case (r_state)
      ST_STABLE: begin
        if (w_diff) begin
          if (DebounceCycles == 1) begin
            // A single agreeing sample is enough: commit without leaving STABLE.
            w_commit  = 1'b1;
            w_cnt_nxt = '0;
          end else begin
            w_state_nxt = ST_CHECK;
            w_cnt_nxt   = CntW'(1);
          end
        end
      end
      ST_CHECK: begin
        if (!w_diff) begin
          w_state_nxt = ST_STABLE;
          w_cnt_nxt   = '0;
        end else if (r_cnt == LastCnt) begin
          w_commit    = 1'b1;
          w_state_nxt = ST_STABLE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      default: begin
        w_state_nxt = ST_STABLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // FSM state and candidate counter.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= ST_STABLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Committed level plus single-cycle edge pulses that line up with the level change.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_level <= ResetValue;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
    end else begin
      if (w_commit) begin
        r_level <= w_sync_s;
      end
      r_rise <= w_commit & w_sync_s;
      r_fall <= w_commit & ~w_sync_s;
    end
  end

  assign signal_o = r_level;
  assign rise_o   = r_rise;
  assign fall_o   = r_fall;
  assign busy_o   = (r_state == ST_CHECK);

endmodule : signal_debouncer

// File: tb/tb_signal_debouncer.sv
// Bench for signal_debouncer: default instance (2 sync stages, 4 debounce cycles)
// and a fast instance (3 sync stages, 1 debounce cycle), both against a
// sample-history reference model.
module tb_signal_debouncer;

  localparam bit RV = 1'b0;

  logic clk = 1'b0;
  logic rst_n;
  logic sig0, sig1;
  logic so0, r0, f0, b0;
  logic so1, r1, f1, b1;

  int errs   = 0;
  int checks = 0;

  always #5 clk = ~clk;

  signal_debouncer u_dut0 (
    .clk_i    (clk),
    .rst_ni   (rst_n),
    .signal_i (sig0),
    .signal_o (so0),
    .rise_o   (r0),
    .fall_o   (f0),
    .busy_o   (b0)
  );

  signal_debouncer #(
    .SyncStages     (3),
    .DebounceCycles (1),
    .ResetValue     (RV)
  ) u_dut1 (
    .clk_i    (clk),
    .rst_ni   (rst_n),
    .signal_i (sig1),
    .signal_o (so1),
    .rise_o   (r1),
    .fall_o   (f1),
    .busy_o   (b1)
  );

  // Reference model: the synchroniser is a pure delay of the sampled input, and a
  // change commits once the last D synchronised samples all disagree with the level.
  int        S [2] = '{2, 3};
  int        D [2] = '{4, 1};
  bit [63:0] hist [2];
  bit [63:0] fh [2];
  int        nv [2];
  bit        lvl [2];
  bit        erise [2];
  bit        efall [2];
  bit        ebusy [2];

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      hist[i]  = {64{RV}};
      fh[i]    = '0;
      nv[i]    = 0;
      lvl[i]   = RV;
      erise[i] = 1'b0;
      efall[i] = 1'b0;
      ebusy[i] = 1'b0;
    end
  endtask

  task automatic model_edge(input bit s0, input bit s1);
    for (int i = 0; i < 2; i++) begin
      bit smp, fin, all_diff, commit;
      smp     = (i == 0) ? s0 : s1;
      fin     = hist[i][S[i]-1];
      hist[i] = {hist[i][62:0], smp};
      fh[i]   = {fh[i][62:0], fin};
      if (nv[i] < 64) nv[i]++;
      all_diff = 1'b1;
      for (int k = 0; k < D[i]; k++) begin
        if (fh[i][k] == lvl[i]) all_diff = 1'b0;
      end
      commit   = (nv[i] >= D[i]) && all_diff;
      erise[i] = commit && fin;
      efall[i] = commit && !fin;
      if (commit) lvl[i] = fin;
      ebusy[i] = (fin != lvl[i]);
    end
  endtask

  function automatic logic [3:0] expv(input int i);
    return {lvl[i], erise[i], efall[i], ebusy[i]};
  endfunction

  function automatic logic [3:0] act(input int i);
    return (i == 0) ? {so0, r0, f0, b0} : {so1, r1, f1, b1};
  endfunction

  // One clock: the model consumes the inputs the DUT sampled, outputs settle 1 ns later.
  task automatic step();
    @(posedge clk);
    if (rst_n) model_edge(sig0, sig1);
    else       model_reset();
    #1;
  endtask

  task automatic settle(input bit v0, input bit v1);
    sig0 = v0;
    sig1 = v1;
    repeat (10) step();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    model_reset();
    for (int e = 0; e < 8; e++) begin
      sig0 = 1'($urandom);
      sig1 = 1'($urandom);
      step();
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (act(i) !== {RV, 3'b000}) begin
          errs++;
          $display("FAIL reset inst%0d cyc%0d: got %b want %b", i, e, act(i), {RV, 3'b000});
        end
      end
    end
    rst_n = 1'b1;
    settle(1'b0, 1'b0);
  endtask

  task automatic test_clean_step();
    logic [3:0] want;
    settle(1'b0, 1'b0);
    sig0 = 1'b1;
    for (int e = 1; e <= 10; e++) begin
      step();
      want = {e >= 6, e == 6, 1'b0, (e >= 3 && e <= 5)};
      checks++;
      if (act(0) !== want) begin
        errs++;
        $display("FAIL clean_step edge%0d: got %b want %b", e, act(0), want);
      end
      checks++;
      if (act(0) !== expv(0)) begin
        errs++;
        $display("FAIL clean_step_model edge%0d: got %b want %b", e, act(0), expv(0));
      end
    end
  endtask

  task automatic test_glitch();
    settle(1'b0, 1'b0);
    sig0 = 1'b1;
    for (int e = 1; e <= 12; e++) begin
      step();
      if (e == 3) sig0 = 1'b0;
      checks++;
      if (act(0)[3:1] !== 3'b000) begin
        errs++;
        $display("FAIL glitch edge%0d: got %b want 000x", e, act(0));
      end
      checks++;
      if (act(0) !== expv(0)) begin
        errs++;
        $display("FAIL glitch_model edge%0d: got %b want %b", e, act(0), expv(0));
      end
    end
    checks++;
    if (b0 !== 1'b0) begin
      errs++;
      $display("FAIL glitch_busy_end: got %b want 0", b0);
    end
  endtask

  task automatic test_fall();
    logic [3:0] want;
    settle(1'b1, 1'b0);
    sig0 = 1'b0;
    for (int e = 1; e <= 10; e++) begin
      step();
      want = {e < 6, 1'b0, e == 6, (e >= 3 && e <= 5)};
      checks++;
      if (act(0) !== want) begin
        errs++;
        $display("FAIL fall edge%0d: got %b want %b", e, act(0), want);
      end
      checks++;
      if (act(0) !== expv(0)) begin
        errs++;
        $display("FAIL fall_model edge%0d: got %b want %b", e, act(0), expv(0));
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [3:0] want;
    settle(1'b0, 1'b0);
    sig0 = 1'b1;
    repeat (4) step();
    checks++;
    if (b0 !== 1'b1) begin
      errs++;
      $display("FAIL reset_mid_busy_before: got %b want 1", b0);
    end
    rst_n = 1'b0;
    #1;
    model_reset();
    checks++;
    if (act(0) !== {RV, 3'b000}) begin
      errs++;
      $display("FAIL reset_mid_async: got %b want %b", act(0), {RV, 3'b000});
    end
    step();
    checks++;
    if (act(0) !== {RV, 3'b000}) begin
      errs++;
      $display("FAIL reset_mid_held: got %b want %b", act(0), {RV, 3'b000});
    end
    rst_n = 1'b1;
    for (int e = 1; e <= 8; e++) begin
      step();
      want = {e >= 6, e == 6, 1'b0, (e >= 3 && e <= 5)};
      checks++;
      if (act(0) !== want) begin
        errs++;
        $display("FAIL reset_mid_after edge%0d: got %b want %b", e, act(0), want);
      end
    end
  endtask

  task automatic test_fast_pulse();
    logic [3:0] want;
    settle(1'b0, 1'b0);
    sig1 = 1'b1;
    for (int e = 1; e <= 8; e++) begin
      step();
      if (e == 1) sig1 = 1'b0;
      want = (e == 4) ? 4'b1100 : (e == 5) ? 4'b0010 : 4'b0000;
      checks++;
      if (act(1) !== want) begin
        errs++;
        $display("FAIL fast_pulse edge%0d: got %b want %b", e, act(1), want);
      end
      checks++;
      if (act(1) !== expv(1)) begin
        errs++;
        $display("FAIL fast_pulse_model edge%0d: got %b want %b", e, act(1), expv(1));
      end
    end
  endtask

  task automatic test_back_to_back();
    int run0;
    run0 = 1;
    for (int e = 0; e < 600; e++) begin
      run0--;
      if (run0 <= 0) begin
        sig0 = ~sig0;
        run0 = int'($urandom_range(1, 7));
      end
      if ($urandom_range(0, 3) == 0) sig1 = ~sig1;
      step();
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (act(i) !== expv(i)) begin
          errs++;
          $display("FAIL random inst%0d cyc%0d: got %b want %b", i, e, act(i), expv(i));
        end
        checks++;
        if (act(i)[2] && act(i)[1]) begin
          errs++;
          $display("FAIL rise_and_fall inst%0d cyc%0d: got %b want not both", i, e, act(i));
        end
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    sig0  = 1'b0;
    sig1  = 1'b0;
    model_reset();
    test_reset();
    test_clean_step();
    test_glitch();
    test_fall();
    test_reset_mid();
    test_fast_pulse();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule : tb_signal_debouncer
